// File: rtl/seg_display.sv
// Four-digit multiplexed 7-segment driver for a common-anode display.
// Shows an operand or ALU result as unsigned decimal 0-255 with an optional minus sign.
module seg_display #(
    parameter int DIV_WIDTH = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] ind_from_sw,
    input  logic [7:0] ind_from_ALU,
    input  logic       c_from_ALU,
    input  logic [1:0] keys,
    input  logic [3:0] arifs,
    output logic [3:0] anodes,
    output logic [7:0] segments
);

    typedef enum logic {
        OPERAND = 1'b0,
        RESULT  = 1'b1
    } mode_t;

    localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [7:0]           disp_val_q;
    logic                 neg_q;
    mode_t                mode_q;
    logic [3:0]           anodes_q,   anodes_d;
    logic [7:0]           segments_q, segments_d;

    logic [1:0]  sel;
    logic [11:0] bcd;
    logic [7:0]  code_ones, code_tens, code_hund, code_sign;

    // Shift-and-add-3 conversion; hundreds never exceeds 2 for an 8-bit input.
    function automatic logic [11:0] bin2bcd(input logic [7:0] bin);
        logic [19:0] sr;
        sr = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sr[11:8]  >= 4'd5) sr[11:8]  = sr[11:8]  + 4'd3;
            if (sr[15:12] >= 4'd5) sr[15:12] = sr[15:12] + 4'd3;
            if (sr[19:16] >= 4'd5) sr[19:16] = sr[19:16] + 4'd3;
            sr = sr << 1;
        end
        return sr[19:8];
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

    always_comb begin
        sel       = cnt_q[DIV_WIDTH-1:DIV_WIDTH-2];
        bcd       = bin2bcd(disp_val_q);
        code_ones = seg_code(bcd[3:0]);
        code_tens = (bcd[11:4] == 8'd0) ? SEG_BLANK : seg_code(bcd[7:4]);
        code_hund = (bcd[11:8] == 4'd0) ? SEG_BLANK : seg_code(bcd[11:8]);
        code_sign = (neg_q && mode_q == RESULT) ? SEG_MINUS : SEG_BLANK;
        anodes_d  = ~(4'b0001 << sel);
        case (sel)
            2'd0:    segments_d = code_ones;
            2'd1:    segments_d = code_tens;
            2'd2:    segments_d = code_hund;
            default: segments_d = code_sign;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q      <= '0;
            disp_val_q <= 8'd0;
            neg_q      <= 1'b0;
            mode_q     <= OPERAND;
            anodes_q   <= 4'hF;
            segments_q <= SEG_BLANK;
        end else begin
            cnt_q      <= cnt_q + CNT_ONE;
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
            // Operand keys win over a simultaneously pressed operation button.
            if (keys == 2'b01 || keys == 2'b10) begin
                disp_val_q <= ind_from_sw;
                neg_q      <= 1'b0;
                mode_q     <= OPERAND;
            end else if (arifs != 4'hF) begin
                disp_val_q <= ind_from_ALU;
                neg_q      <= c_from_ALU;
                mode_q     <= RESULT;
            end
        end
    end

    assign anodes   = anodes_q;
    assign segments = segments_q;

endmodule

// File: tb/tb_seg_display.sv
// Bench for seg_display with DIV_WIDTH=4: per-cycle scoreboard against a decimal
// reference model, plus a table of loads with the digit codes each must produce.
module tb_seg_display;
  localparam int DW = 4;

  logic       clk;
  logic       rst;
  logic [7:0] sw_val;
  logic [7:0] alu_val;
  logic       c_alu;
  logic [1:0] keys;
  logic [3:0] arifs;
  logic [3:0] anodes;
  logic [7:0] segments;

  seg_display #(.DIV_WIDTH(DW)) dut (
    .Clk          (clk),
    .Rst          (rst),
    .ind_from_sw  (sw_val),
    .ind_from_ALU (alu_val),
    .c_from_ALU   (c_alu),
    .keys         (keys),
    .arifs        (arifs),
    .anodes       (anodes),
    .segments     (segments)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [DW-1:0] m_cnt;
  logic [7:0]    m_val;
  logic          m_neg;
  logic [1:0]    last_sel;
  logic [7:0]    seg_lut [10];

  // scoreboard: {anodes, segments}
  logic [11:0] exp_q[$];
  int n_checks;
  int n_errors;

  typedef struct packed {
    logic [1:0]  keys;
    logic [3:0]  arifs;
    logic [7:0]  sw;
    logic [7:0]  alu;
    logic        c;
    logic [31:0] exp_segs; // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [11];

  function automatic logic [7:0] model_code(input logic [1:0] s);
    int h, t, o;
    logic [7:0] c;
    h = int'(m_val) / 100;
    t = (int'(m_val) / 10) % 10;
    o = int'(m_val) % 10;
    case (s)
      2'd0:    c = seg_lut[o];
      2'd1:    c = (h == 0 && t == 0) ? 8'hFF : seg_lut[t];
      2'd2:    c = (h == 0) ? 8'hFF : seg_lut[h];
      default: c = m_neg ? 8'hBF : 8'hFF;
    endcase
    return c;
  endfunction

  task automatic check_val(input string name, input logic [11:0] got, input logic [11:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got anodes=%h segments=%h, expected anodes=%h segments=%h",
               name, got[11:8], got[7:0], want[11:8], want[7:0]);
    end
  endtask

  task automatic check_out();
    logic [11:0] want;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: expected queue empty at t=%0t", $time);
    end else begin
      want = exp_q.pop_front();
      check_val("scoreboard", {anodes, segments}, want);
    end
  endtask

  // driver: one clock with the given inputs, model update, then compare
  task automatic drive_cycle(input logic r, input logic [1:0] k, input logic [3:0] a,
                             input logic [7:0] sw, input logic [7:0] alu, input logic c);
    logic [1:0] s;
    @(negedge clk);
    rst = r; keys = k; arifs = a; sw_val = sw; alu_val = alu; c_alu = c;
    s = m_cnt[DW-1:DW-2];
    last_sel = s;
    if (r) exp_q.push_back({4'hF, 8'hFF});
    else   exp_q.push_back({~(4'b0001 << s), model_code(s)});
    if (r) begin
      m_cnt = '0; m_val = 8'd0; m_neg = 1'b0;
    end else begin
      m_cnt = m_cnt + 1'b1;
      if (k == 2'b01 || k == 2'b10) begin
        m_val = sw; m_neg = 1'b0;
      end else if (a != 4'hF) begin
        m_val = alu; m_neg = c;
      end
    end
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic idle_cycle();
    logic [1:0] k;
    k = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    drive_cycle(1'b0, k, 4'hF, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)));
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; keys = 2'b00; arifs = 4'hF; sw_val = 8'd0; alu_val = 8'd0; c_alu = 1'b0;
    m_cnt = '0; m_val = 8'd0; m_neg = 1'b0; last_sel = 2'd0;
    seg_lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    vecs[0]  = '{keys: 2'b01, arifs: 4'hF, sw: 8'd7,   alu: 8'd0,   c: 1'b0, exp_segs: 32'hFF_FF_FF_F8};
    vecs[1]  = '{keys: 2'b00, arifs: 4'hE, sw: 8'd0,   alu: 8'd123, c: 1'b1, exp_segs: 32'hBF_F9_A4_B0};
    vecs[2]  = '{keys: 2'b00, arifs: 4'hF, sw: 8'd0,   alu: 8'd5,   c: 1'b0, exp_segs: 32'hBF_F9_A4_B0};
    vecs[3]  = '{keys: 2'b10, arifs: 4'h7, sw: 8'd9,   alu: 8'd200, c: 1'b1, exp_segs: 32'hFF_FF_FF_90};
    vecs[4]  = '{keys: 2'b11, arifs: 4'hF, sw: 8'd55,  alu: 8'd0,   c: 1'b0, exp_segs: 32'hFF_FF_FF_90};
    vecs[5]  = '{keys: 2'b00, arifs: 4'hB, sw: 8'd0,   alu: 8'd255, c: 1'b0, exp_segs: 32'hFF_A4_92_92};
    vecs[6]  = '{keys: 2'b00, arifs: 4'hB, sw: 8'd0,   alu: 8'd100, c: 1'b0, exp_segs: 32'hFF_F9_C0_C0};
    vecs[7]  = '{keys: 2'b00, arifs: 4'hB, sw: 8'd0,   alu: 8'd10,  c: 1'b0, exp_segs: 32'hFF_FF_F9_C0};
    vecs[8]  = '{keys: 2'b00, arifs: 4'hD, sw: 8'd0,   alu: 8'd0,   c: 1'b1, exp_segs: 32'hBF_FF_FF_C0};
    vecs[9]  = '{keys: 2'b01, arifs: 4'h0, sw: 8'd250, alu: 8'd1,   c: 1'b1, exp_segs: 32'hFF_A4_92_C0};
    vecs[10] = '{keys: 2'b00, arifs: 4'hF, sw: 8'd0,   alu: 8'd0,   c: 1'b0, exp_segs: 32'hFF_A4_92_C0};

    // reset held two cycles, then first lit digit is '0'
    drive_cycle(1'b1, 2'b00, 4'hF, 8'd0, 8'd0, 1'b0);
    drive_cycle(1'b1, 2'b00, 4'hF, 8'd0, 8'd0, 1'b0);
    check_val("reset_dark", {anodes, segments}, {4'hF, 8'hFF});
    drive_cycle(1'b0, 2'b00, 4'hF, 8'd0, 8'd0, 1'b0);
    check_val("first_digit", {anodes, segments}, {4'hE, 8'hC0});
    for (int i = 0; i < 15; i++) idle_cycle();

    // table of loads, each followed by three full scans checked against the table
    for (int v = 0; v < 11; v++) begin
      drive_cycle(1'b0, vecs[v].keys, vecs[v].arifs, vecs[v].sw, vecs[v].alu, vecs[v].c);
      for (int i = 0; i < 48; i++) begin
        if (v == 2 || v == 10) drive_cycle(1'b0, 2'b00, 4'hF, 8'($urandom_range(0, 255)),
                                           8'($urandom_range(0, 255)), 1'b1);
        else idle_cycle();
        n_checks++;
        if (segments !== vecs[v].exp_segs[last_sel*8 +: 8]) begin
          n_errors++;
          $display("FAIL table[%0d] digit %0d: got segments=%h, expected %h",
                   v, last_sel, segments, vecs[v].exp_segs[last_sel*8 +: 8]);
        end
      end
    end

    // reset in the middle of a scan
    for (int i = 0; i < 16 && m_cnt[DW-1:DW-2] != 2'd2; i++) idle_cycle();
    drive_cycle(1'b1, 2'b00, 4'hF, 8'd0, 8'd0, 1'b0);
    check_val("midscan_reset", {anodes, segments}, {4'hF, 8'hFF});
    drive_cycle(1'b0, 2'b00, 4'hF, 8'd0, 8'd0, 1'b0);
    check_val("midscan_restart", {anodes, segments}, {4'hE, 8'hC0});

    // random traffic through many wraps
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
    end

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
